sd_data_check: RTL and testbench
================================

Name: sd_data_check

Overview:
- Read-data checker for the TF-card test path.
- Compares a stream of 16-bit words read back from the card against the known incrementing pattern written by the test writer.
- Produces the sticky error_flag consumed by the LED alarm block, plus error count, first-error index, timeout and done status.
- Sits between the card read engine (word strobe + data) and the LED alarm / status logic.

Parameters:
- BLK_WORDS, 256, 16-bit words per 512-byte sector.
- NUM_BLKS, 4, sectors per check pass; total words per pass N = NUM_BLKS*BLK_WORDS, must satisfy 1 <= N <= 65536.
- SEED, 16'd0, expected value of word 0 of a pass.
- TIMEOUT, 25'd25_000_000, max idle cycles between words during a pass (0.5 s at 50 MHz); must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a new check pass.
- rd_val_en  in  1  read word valid strobe, one word per high cycle.
- rd_val_data  in  16  read word.
- error_flag  out  1  sticky error indication; high on any mismatch or timeout in the current or last pass.
- check_done  out  1  level; high once the pass completes or times out.
- timeout  out  1  sticky; pass aborted by idle watchdog.
- err_cnt  out  16  mismatched-word count, saturating at 16'hFFFF.
- first_err_idx  out  16  word index (0..N-1) of the first mismatch; 0 if none.
- busy  out  1  high while in CHECK.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All outputs are 0, state is IDLE, and the internal word index, expected value and idle counter are 0.
- States: IDLE, CHECK, DONE, encoded in registers.
- IDLE:
  - start -> CHECK.
  - rd_val_en is ignored.
- Entry to CHECK (any state, including a start pulse during CHECK, which restarts the pass):
  - idx=0, expected=SEED.
  - err_cnt=0, first_err_idx=0, idle counter=0.
  - error_flag, timeout and check_done are cleared.
  - busy is high from the cycle after start.
- Word acceptance in CHECK: rd_val_en high accepts one word per cycle; back-to-back strobes are legal.
  - Compare rd_val_data with expected.
  - On mismatch:
    - err_cnt increments, holding at 16'hFFFF.
    - If err_cnt was 0, first_err_idx <= idx.
    - error_flag <= 1.
  - All of the above are registered, so error_flag rises on the cycle after the bad word.
  - expected <= expected+1, wrapping mod 2^16.
  - idx <= idx+1.
  - Idle counter is cleared.
- Pass completion: the word with idx==N-1 is accepted (and checked) -> DONE next cycle. At that point:
  - check_done=1.
  - busy=0.
- Watchdog: in CHECK, each cycle without rd_val_en increments the idle counter. When it reaches TIMEOUT-1 with no strobe:
  - timeout<=1, error_flag<=1.
  - Go to DONE; check_done=1.
  - err_cnt is unchanged.
- If a strobe arrives in the same cycle the idle counter reaches TIMEOUT-1, the strobe wins: the word is accepted and there is no timeout.
- start and rd_val_en in the same cycle: start wins; the word is discarded and the pass restarts.
- DONE:
  - All status outputs hold.
  - rd_val_en is ignored.
  - start -> CHECK.
- error_flag is cleared only by start or reset, never by a subsequent good word.
- Reset asserted mid-pass: immediate return to the reset state, with no partial status retained.

Test Plan:
- Clean pass, default params:
  - Stimulus: start, then 1024 strobed words 0x0000..0x03FF back-to-back.
  - Response: check_done=1 the cycle after the last word; error_flag=0, err_cnt=0, timeout=0, busy=0.
- Single corruption:
  - Stimulus: as the clean pass, but word 300 = 0xBEEF.
  - Response: error_flag rises the cycle after word 300 and stays high; err_cnt=1, first_err_idx=300; check_done after 1024 words.
- Gapped stream and timeout, with TIMEOUT=16:
  - Words with 10-cycle gaps -> no timeout.
  - Then stop strobing after word 5 -> timeout=1, error_flag=1, check_done=1 sixteen cycles later; err_cnt=0.
- Restart mid-pass:
  - Stimulus: corrupt word 3, then start at word 10, followed by a full clean pass.
  - Response: error_flag, err_cnt and first_err_idx cleared; end with error_flag=0 and check_done=1. Also check that start coinciding with a strobe discards that word.
- Saturation and wrap, with NUM_BLKS=256, SEED=16'hFFF0:
  - Expected wraps 0xFFFF->0x0000 with no false error.
  - Then feed all words wrong -> err_cnt saturates at 0xFFFF and first_err_idx=0.
- Async reset mid-pass:
  - Stimulus: assert rst_n low for 1 cycle at word 500 after an error.
  - Response: all outputs 0 immediately; start is required before words are checked again.

Source files
------------

// File: rtl/sd_data_check.sv
// Checks TF-card read-back words against the incrementing pattern SEED, SEED+1, ...
// Status registers update the cycle after each accepted word; the checker never stalls the read engine.
module sd_data_check #(
  parameter int unsigned BLK_WORDS = 256,
  parameter int unsigned NUM_BLKS  = 4,
  parameter logic [15:0] SEED      = 16'd0,
  parameter logic [24:0] TIMEOUT   = 25'd25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rd_val_en,
  input  logic [15:0] rd_val_data,
  output logic        error_flag,
  output logic        check_done,
  output logic        timeout,
  output logic [15:0] err_cnt,
  output logic [15:0] first_err_idx,
  output logic        busy
);

  localparam int unsigned N        = BLK_WORDS * NUM_BLKS;
  localparam logic [15:0] LAST_IDX = 16'(N - 1);
  localparam logic [24:0] IDLE_MAX = TIMEOUT - 25'd1;

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t      state;
  logic [15:0] idx;
  logic [15:0] expected;
  logic [24:0] idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= 16'd0;
      expected      <= 16'd0;
      idle_cnt      <= 25'd0;
      error_flag    <= 1'b0;
      check_done    <= 1'b0;
      timeout       <= 1'b0;
      err_cnt       <= 16'd0;
      first_err_idx <= 16'd0;
      busy          <= 1'b0;
    end else if (start) begin
      // start wins over a coincident strobe, from any state
      state         <= CHECK;
      idx           <= 16'd0;
      expected      <= SEED;
      idle_cnt      <= 25'd0;
      error_flag    <= 1'b0;
      check_done    <= 1'b0;
      timeout       <= 1'b0;
      err_cnt       <= 16'd0;
      first_err_idx <= 16'd0;
      busy          <= 1'b1;
    end else if (state == CHECK) begin
      if (rd_val_en) begin
        if (rd_val_data != expected) begin
          if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
          if (err_cnt == 16'd0) first_err_idx <= idx;
          error_flag <= 1'b1;
        end
        expected <= expected + 16'd1;
        idx      <= idx + 16'd1;
        idle_cnt <= 25'd0;
        if (idx == LAST_IDX) begin
          state      <= DONE;
          check_done <= 1'b1;
          busy       <= 1'b0;
        end
      end else if (idle_cnt == IDLE_MAX) begin
        // a strobe arriving on this same cycle is taken by the branch above instead
        timeout    <= 1'b1;
        error_flag <= 1'b1;
        state      <= DONE;
        check_done <= 1'b1;
        busy       <= 1'b0;
      end else begin
        idle_cnt <= idle_cnt + 25'd1;
      end
    end
  end

endmodule

// File: tb/tb_sd_data_check.sv
// Bench for sd_data_check: a small-pass instance against a word-level model, and a full 64K-word instance for wrap/saturation.
`timescale 1ns/1ps
module tb_sd_data_check;

  localparam int          A_N    = 1024;
  localparam int          TO     = 16;
  localparam logic [15:0] B_SEED = 16'hFFF0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_start, a_en;
  logic [15:0] a_data;
  logic        a_error_flag, a_check_done, a_timeout, a_busy;
  logic [15:0] a_err_cnt, a_first_err_idx;

  logic        b_start, b_en;
  logic [15:0] b_data;
  logic        b_error_flag, b_check_done, b_timeout, b_busy;
  logic [15:0] b_err_cnt, b_first_err_idx;

  sd_data_check #(.BLK_WORDS(256), .NUM_BLKS(4), .SEED(16'd0), .TIMEOUT(25'(TO))) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .rd_val_en(a_en), .rd_val_data(a_data),
    .error_flag(a_error_flag), .check_done(a_check_done), .timeout(a_timeout),
    .err_cnt(a_err_cnt), .first_err_idx(a_first_err_idx), .busy(a_busy)
  );

  sd_data_check #(.BLK_WORDS(256), .NUM_BLKS(256), .SEED(B_SEED), .TIMEOUT(25'(TO))) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .rd_val_en(b_en), .rd_val_data(b_data),
    .error_flag(b_error_flag), .check_done(b_check_done), .timeout(b_timeout),
    .err_cnt(b_err_cnt), .first_err_idx(b_first_err_idx), .busy(b_busy)
  );

  wire [35:0] a_vec = {a_error_flag, a_check_done, a_timeout, a_busy, a_err_cnt, a_first_err_idx};
  wire [35:0] b_vec = {b_error_flag, b_check_done, b_timeout, b_busy, b_err_cnt, b_first_err_idx};

  int checks = 0;
  int errors = 0;

  // Word-level reference for dut_a: pass position, mismatch tally, consecutive idle cycles.
  int m_idx, m_err, m_first, m_idle;
  bit m_flag, m_done, m_to, m_busy;

  function automatic logic [35:0] model_vec();
    return {m_flag, m_done, m_to, m_busy, 16'(m_err), 16'(m_first)};
  endfunction

  task automatic model_clear();
    m_idx = 0; m_err = 0; m_first = 0; m_idle = 0;
    m_flag = 0; m_done = 0; m_to = 0; m_busy = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_pulse_start(input bit with_word);
    a_start = 1'b1;
    a_en    = with_word;
    a_data  = 16'($urandom);
    tick();
    a_start = 1'b0;
    a_en    = 1'b0;
    model_clear();
    m_busy = 1;
  endtask

  task automatic a_send(input logic [15:0] d);
    a_en   = 1'b1;
    a_data = d;
    tick();
    a_en = 1'b0;
    if (m_busy) begin
      if (d != 16'(m_idx)) begin
        if (m_err == 0) m_first = m_idx;
        if (m_err < 65535) m_err++;
        m_flag = 1;
      end
      m_idx++;
      m_idle = 0;
      if (m_idx == A_N) begin
        m_busy = 0;
        m_done = 1;
      end
    end
  endtask

  // A pass times out on its TO-th consecutive cycle without a word.
  task automatic a_gap(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (m_busy) begin
        m_idle++;
        if (m_idle == TO) begin
          m_to = 1; m_flag = 1; m_done = 1; m_busy = 0;
        end
      end
    end
  endtask

  task automatic test_reset();
    a_start = 0; a_en = 0; a_data = 0;
    b_start = 0; b_en = 0; b_data = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_clear();
    tick();
    tick();
    checks++;
    if (a_vec !== model_vec()) begin
      errors++; $display("FAIL reset_a: got %h want %h", a_vec, model_vec());
    end
    checks++;
    if (b_vec !== 36'd0) begin
      errors++; $display("FAIL reset_b: got %h want %h", b_vec, 36'd0);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clean_pass();
    a_pulse_start(0);
    checks++;
    if (a_vec !== model_vec()) begin
      errors++; $display("FAIL clean_start: got %h want %h", a_vec, model_vec());
    end
    for (int i = 0; i < A_N - 1; i++) a_send(16'(i));
    checks++;
    if (a_vec !== model_vec()) begin
      errors++; $display("FAIL clean_before_last: got %h want %h", a_vec, model_vec());
    end
    a_send(16'(A_N - 1));
    checks++;
    if (a_vec !== model_vec() || a_check_done !== 1'b1) begin
      errors++; $display("FAIL clean_end: got %h want %h", a_vec, model_vec());
    end
    for (int i = 0; i < 5; i++) a_send(16'($urandom));
    checks++;
    if (a_vec !== model_vec()) begin
      errors++; $display("FAIL done_hold: got %h want %h", a_vec, model_vec());
    end
  endtask

  task automatic test_single_corruption();
    a_pulse_start(0);
    for (int i = 0; i < A_N; i++) begin
      a_send((i == 300) ? 16'hBEEF : 16'(i));
      if (i == 299 || i == 300 || i == 301 || i == 700 || i == A_N - 1) begin
        checks++;
        if (a_vec !== model_vec()) begin
          errors++; $display("FAIL corrupt_w%0d: got %h want %h", i, a_vec, model_vec());
        end
      end
    end
    checks++;
    if (a_err_cnt !== 16'd1 || a_first_err_idx !== 16'd300) begin
      errors++; $display("FAIL corrupt_summary: got cnt=%0d idx=%0d want cnt=1 idx=300", a_err_cnt, a_first_err_idx);
    end
  endtask

  task automatic test_gapped_timeout();
    a_pulse_start(0);
    for (int i = 0; i < 20; i++) begin
      a_gap((i == 7) ? TO - 1 : int'($urandom_range(0, 10)));
      a_send(16'(i));
    end
    checks++;
    if (a_vec !== model_vec() || a_timeout !== 1'b0) begin
      errors++; $display("FAIL gapped_no_timeout: got %h want %h", a_vec, model_vec());
    end
    a_pulse_start(0);
    for (int i = 0; i <= 5; i++) a_send(16'(i));
    a_gap(TO - 1);
    checks++;
    if (a_vec !== model_vec() || a_busy !== 1'b1) begin
      errors++; $display("FAIL timeout_early: got %h want %h", a_vec, model_vec());
    end
    a_gap(1);
    checks++;
    if (a_vec !== model_vec() || a_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_fire: got %h want %h", a_vec, model_vec());
    end
    a_send(16'd6);
    a_gap(3);
    checks++;
    if (a_vec !== model_vec()) begin
      errors++; $display("FAIL timeout_hold: got %h want %h", a_vec, model_vec());
    end
  endtask

  task automatic test_restart();
    a_pulse_start(0);
    for (int i = 0; i < 10; i++) a_send((i == 3) ? 16'(i) ^ 16'h5A5A : 16'(i));
    checks++;
    if (a_vec !== model_vec() || a_first_err_idx !== 16'd3) begin
      errors++; $display("FAIL restart_pre: got %h want %h", a_vec, model_vec());
    end
    a_pulse_start(1);
    checks++;
    if (a_vec !== model_vec()) begin
      errors++; $display("FAIL restart_clear: got %h want %h", a_vec, model_vec());
    end
    for (int i = 0; i < A_N; i++) a_send(16'(i));
    checks++;
    if (a_vec !== model_vec() || a_error_flag !== 1'b0 || a_check_done !== 1'b1) begin
      errors++; $display("FAIL restart_end: got %h want %h", a_vec, model_vec());
    end
    a_pulse_start(0);
    a_send(16'hFFFF);
    checks++;
    if (a_vec !== model_vec()) begin
      errors++; $display("FAIL restart_from_done: got %h want %h", a_vec, model_vec());
    end
  endtask

  task automatic test_random_stream();
    a_pulse_start(0);
    for (int i = 0; i < A_N; i++) begin
      logic [15:0] d;
      d = 16'(i);
      if ($urandom_range(0, 7) == 0) d = d ^ 16'($urandom_range(1, 65535));
      a_gap(int'($urandom_range(0, 2)));
      a_send(d);
      checks++;
      if (a_vec !== model_vec()) begin
        errors++; $display("FAIL random_w%0d: got %h want %h", i, a_vec, model_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    int k;
    k = int'($urandom_range(0, 499));
    a_pulse_start(0);
    for (int i = 0; i < 500; i++) a_send((i == k) ? ~16'(i) : 16'(i));
    checks++;
    if (a_vec !== model_vec() || a_first_err_idx !== 16'(k)) begin
      errors++; $display("FAIL prereset: got %h want %h", a_vec, model_vec());
    end
    rst_n = 1'b0;
    #2;
    model_clear();
    checks++;
    if (a_vec !== model_vec()) begin
      errors++; $display("FAIL async_reset_now: got %h want %h", a_vec, model_vec());
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) a_send(16'(500 + i));
    checks++;
    if (a_vec !== model_vec()) begin
      errors++; $display("FAIL post_reset_ignore: got %h want %h", a_vec, model_vec());
    end
    a_pulse_start(0);
    for (int i = 0; i < 5; i++) a_send((i == 2) ? 16'h1234 : 16'(i));
    checks++;
    if (a_vec !== model_vec()) begin
      errors++; $display("FAIL post_reset_pass: got %h want %h", a_vec, model_vec());
    end
  endtask

  task automatic test_wrap_sat();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      b_en = 1'b1;
      b_data = B_SEED + 16'(i);
      tick();
      if (i == 15 || i == 16 || i == 39) begin
        checks++;
        if (b_error_flag !== 1'b0 || b_err_cnt !== 16'd0 || b_busy !== 1'b1) begin
          errors++; $display("FAIL wrap_w%0d: got flag=%b cnt=%0d busy=%b want 0 0 1", i, b_error_flag, b_err_cnt, b_busy);
        end
      end
    end
    b_en = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      b_en = 1'b1;
      b_data = ~(B_SEED + 16'(i));
      tick();
      if (i == 999 || i == 65534) begin
        checks++;
        if (b_err_cnt !== 16'(i + 1) || b_check_done !== 1'b0) begin
          errors++; $display("FAIL sat_w%0d: got cnt=%0d done=%b want cnt=%0d done=0", i, b_err_cnt, b_check_done, i + 1);
        end
      end
    end
    b_en = 1'b0;
    checks++;
    if (b_vec !== {1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'd0}) begin
      errors++; $display("FAIL sat_end: got %h want %h", b_vec, {1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'd0});
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "time budget expired");
  end

  initial begin
    test_reset();
    test_clean_pass();
    test_single_corruption();
    test_gapped_timeout();
    test_restart();
    test_random_stream();
    test_async_reset();
    test_wrap_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
